fifo_csr_ctrl: RTL and testbench

AXI4-Lite register controller and flush sequencer for the async FIFO. It sits in the `axi_clk` domain between the AXI manager and the FIFO core. It decodes CTRL/STATUS/EVENT/FLUSH_CNT registers and synchronises the FIFO `full`/`empty` flags into `axi_clk`. It also drives the FIFO `flush` line with a guaranteed minimum hold, so the slower `w_clk`/`r_clk` domains always observe it.

---
 rtl/fifo_csr_pkg.sv | 53 +++++
 rtl/sync_2ff.sv | 34 +++
 rtl/fifo_csr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_fifo_csr_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_csr_pkg
// Description : Shared definitions for the async-FIFO CSR controller:
//               register addresses, bit positions, AXI response codes and
//               the state encodings of the write, read and flush FSMs.
// Revision    : 1.0  initial release
// ============================================================================
package fifo_csr_pkg;

    // Register addresses
    localparam logic [7:0] CSR_CTRL      = 8'h00;
    localparam logic [7:0] CSR_STATUS    = 8'h01;
    localparam logic [7:0] CSR_EVENT     = 8'h02;
    localparam logic [7:0] CSR_FLUSH_CNT = 8'h03;

    // CTRL bits
    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bits
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_BUSY_BIT  = 2;

    // EVENT bits
    localparam int EV_FULL_BIT  = 0;
    localparam int EV_EMPTY_BIT = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // W_PART: exactly one of the address/data beats is held.
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PART = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_ACTIVE = 2'd1,
        F_HOLD   = 2'd2
    } f_state_e;

endpackage : fifo_csr_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser with synchronous active-low reset.
//   clk    : destination clock
//   rst_n  : synchronous active-low reset
//   i_d    : asynchronous input
//   o_q    : synchronised output (two destination-clock cycles of latency)
// Revision    : 1.0  initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/fifo_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_csr_ctrl
// Description : AXI4-Lite register block and flush sequencer for the async
//               FIFO. Decodes CTRL/STATUS/EVENT/FLUSH_CNT, synchronises the
//               FIFO full/empty flags into axi_clk, and stretches the FIFO
//               flush line so slower FIFO clock domains always see it.
//   axi_clk, axi_rst_n      : clock, synchronous active-low reset
//   aw*/w*/b*               : AXI4-Lite write channels
//   ar*/r*                  : AXI4-Lite read channels
//   fifo_full, fifo_empty   : asynchronous FIFO flags
//   flush                   : registered FIFO flush request
//   irq                     : registered level interrupt
// Revision    : 1.0  initial release
// ============================================================================
module fifo_csr_ctrl
    import fifo_csr_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FLUSH_HOLD = 8
) (
    input  logic              axi_clk,
    input  logic              axi_rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              flush,
    output logic              irq
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    w_state_e          w_state_q,   w_state_d;
    logic              aw_held_q,   aw_held_d;
    logic              w_held_q,    w_held_d;
    logic [ADDR_W-1:0] awaddr_q,    awaddr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              awready_q,   awready_d;
    logic              wready_q,    wready_d;
    logic              bvalid_q,    bvalid_d;
    logic [1:0]        bresp_q,     bresp_d;

    r_state_e          r_state_q,   r_state_d;
    logic              arready_q,   arready_d;
    logic              rvalid_q,    rvalid_d;
    logic [1:0]        rresp_q,     rresp_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;

    logic              ctrl_flush_q, ctrl_flush_d;
    logic              irq_en_q,     irq_en_d;
    logic [1:0]        event_q,      event_d;
    logic [7:0]        flush_cnt_q,  flush_cnt_d;
    logic              full_prev_q,  full_prev_d;
    logic              empty_prev_q, empty_prev_d;

    f_state_e          f_state_q,   f_state_d;
    logic [7:0]        hold_cnt_q,  hold_cnt_d;
    logic              flush_q,     flush_d;
    logic              irq_q,       irq_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_full_s;
    logic              w_empty_s;
    logic              w_aw_fire, w_w_fire, w_ar_fire;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [1:0]        w_ev_clr;
    logic [1:0]        w_ev_set;
    logic [7:0]        w_rd_val;
    logic              w_rd_ok;
    logic              w_unused;

    sync_2ff u_sync_full (
        .clk   (axi_clk),
        .rst_n (axi_rst_n),
        .i_d   (fifo_full),
        .o_q   (w_full_s)
    );

    sync_2ff u_sync_empty (
        .clk   (axi_clk),
        .rst_n (axi_rst_n),
        .i_d   (fifo_empty),
        .o_q   (w_empty_s)
    );

    // Only the low two data bits are architecturally meaningful.
    assign w_unused = ^w_wr_data[DATA_W-1:2];

    always_comb begin
        w_state_d    = w_state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        r_state_d    = r_state_q;
        rvalid_d     = rvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        ctrl_flush_d = ctrl_flush_q;
        irq_en_d     = irq_en_q;
        flush_cnt_d  = flush_cnt_q;
        f_state_d    = f_state_q;
        hold_cnt_d   = hold_cnt_q;
        w_wr_en      = 1'b0;
        w_ev_clr     = 2'b00;

        // -------------------- write channel --------------------
        w_aw_fire = awvalid && awready_q;
        w_w_fire  = wvalid  && wready_q;
        // A beat arriving this cycle is used directly so that both beats
        // in the same cycle complete on the very next edge.
        w_wr_addr = aw_held_q ? awaddr_q : awaddr;
        w_wr_data = w_held_q  ? wdata_q  : wdata;

        case (w_state_q)
            W_IDLE, W_PART: begin
                if ((aw_held_q || w_aw_fire) && (w_held_q || w_w_fire)) begin
                    w_wr_en   = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = (w_wr_addr > ADDR_W'(CSR_FLUSH_CNT)) ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end else begin
                    if (w_aw_fire) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = awaddr;
                    end
                    if (w_w_fire) begin
                        w_held_d = 1'b1;
                        wdata_d  = wdata;
                    end
                    w_state_d = (aw_held_d || w_held_d) ? W_PART : W_IDLE;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d != W_RESP) && !aw_held_d;
        wready_d  = (w_state_d != W_RESP) && !w_held_d;

        // -------------------- register updates --------------------
        if (w_wr_en) begin
            case (w_wr_addr)
                ADDR_W'(CSR_CTRL): begin
                    ctrl_flush_d = w_wr_data[CTRL_FLUSH_BIT];
                    irq_en_d     = w_wr_data[CTRL_IRQ_EN_BIT];
                    if (w_wr_data[CTRL_FLUSH_BIT] && !ctrl_flush_q && (flush_cnt_q != 8'hFF)) begin
                        flush_cnt_d = flush_cnt_q + 8'd1;
                    end
                end
                ADDR_W'(CSR_EVENT): begin
                    w_ev_clr[EV_FULL_BIT]  = w_wr_data[EV_FULL_BIT];
                    w_ev_clr[EV_EMPTY_BIT] = w_wr_data[EV_EMPTY_BIT];
                end
                default: ;
            endcase
        end

        // Set has priority over a W1C clear landing on the same edge.
        w_ev_set               = 2'b00;
        w_ev_set[EV_FULL_BIT]  = w_full_s  && !full_prev_q;
        w_ev_set[EV_EMPTY_BIT] = w_empty_s && !empty_prev_q;
        event_d      = (event_q & ~w_ev_clr) | w_ev_set;
        full_prev_d  = w_full_s;
        empty_prev_d = w_empty_s;
        irq_d        = irq_en_q && (|event_q);

        // -------------------- read channel --------------------
        // The mux reads current register state, so a read sampled on a
        // write-update edge returns the pre-write value.
        w_rd_val = 8'h00;
        w_rd_ok  = 1'b1;
        case (araddr)
            ADDR_W'(CSR_CTRL): begin
                w_rd_val[CTRL_FLUSH_BIT]  = ctrl_flush_q;
                w_rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            ADDR_W'(CSR_STATUS): begin
                w_rd_val[ST_EMPTY_BIT] = w_empty_s;
                w_rd_val[ST_FULL_BIT]  = w_full_s;
                w_rd_val[ST_BUSY_BIT]  = (f_state_q != F_IDLE);
            end
            ADDR_W'(CSR_EVENT):     w_rd_val[1:0] = event_q;
            ADDR_W'(CSR_FLUSH_CNT): w_rd_val      = flush_cnt_q;
            default:                w_rd_ok       = 1'b0;
        endcase

        w_ar_fire = arvalid && arready_q;
        case (r_state_q)
            R_IDLE: begin
                if (w_ar_fire) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = DATA_W'(w_rd_val);
                    rresp_d   = w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);

        // -------------------- flush sequencer --------------------
        case (f_state_q)
            F_IDLE: begin
                if (ctrl_flush_q) f_state_d = F_ACTIVE;
            end
            F_ACTIVE: begin
                if (!ctrl_flush_q) begin
                    // The ACTIVE->HOLD edge is itself the first hold cycle,
                    // so the counter holds the cycles still remaining after it.
                    if (FLUSH_HOLD <= 1) begin
                        f_state_d = F_IDLE;
                    end else begin
                        f_state_d  = F_HOLD;
                        hold_cnt_d = 8'(FLUSH_HOLD - 1);
                    end
                end
            end
            F_HOLD: begin
                if (ctrl_flush_q) begin
                    f_state_d = F_ACTIVE;
                end else if (hold_cnt_q <= 8'd1) begin
                    f_state_d = F_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            default: f_state_d = F_IDLE;
        endcase
        flush_d = (f_state_d != F_IDLE);
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_rst_n) begin
            w_state_q    <= W_IDLE;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            r_state_q    <= R_IDLE;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b00;
            rdata_q      <= '0;
            ctrl_flush_q <= 1'b0;
            irq_en_q     <= 1'b0;
            event_q      <= 2'b00;
            flush_cnt_q  <= 8'h00;
            full_prev_q  <= 1'b0;
            empty_prev_q <= 1'b0;
            f_state_q    <= F_IDLE;
            hold_cnt_q   <= 8'h00;
            flush_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            r_state_q    <= r_state_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            ctrl_flush_q <= ctrl_flush_d;
            irq_en_q     <= irq_en_d;
            event_q      <= event_d;
            flush_cnt_q  <= flush_cnt_d;
            full_prev_q  <= full_prev_d;
            empty_prev_q <= empty_prev_d;
            f_state_q    <= f_state_d;
            hold_cnt_q   <= hold_cnt_d;
            flush_q      <= flush_d;
            irq_q        <= irq_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign flush   = flush_q;
    assign irq     = irq_q;

endmodule : fifo_csr_ctrl
`default_nettype wire

// File: tb/tb_fifo_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_csr_ctrl
// Description : Directed self-checking bench for fifo_csr_ctrl
//               (ADDR_W=8, DATA_W=8, FLUSH_HOLD=8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_csr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] awaddr;
    logic       awvalid;
    logic       awready;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;
    logic [7:0] araddr;
    logic       arvalid;
    logic       arready;
    logic [7:0] rdata;
    logic [1:0] rresp;
    logic       rvalid;
    logic       rready;
    logic       fifo_full;
    logic       fifo_empty;
    logic       flush;
    logic       irq;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic       flush_at_upd;
    logic       irq_at_upd;

    always #5 clk = ~clk;

    fifo_csr_ctrl #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .FLUSH_HOLD (8)
    ) dut (
        .axi_clk    (clk),
        .axi_rst_n  (rst_n),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .flush      (flush),
        .irq        (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write with both beats presented together; returns one cycle after
    // the update edge. Captures flush/irq as seen right at the update edge.
    task automatic axi_write(input logic [7:0] a, input logic [7:0] d, output logic [1:0] resp);
        logic aw_hs, w_hs, got_b;
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        flush_at_upd = flush;
        irq_at_upd   = irq;
        got_b = 1'b0;
        resp  = 2'b11;
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (bvalid) begin
                got_b = 1'b1;
                resp  = bresp;
                bready = 1'b1;
            end
            tick();
        end
        bready = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!got_b) check_eq("write_timeout", 32'(got_b), 32'd1);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [7:0] d, output logic [1:0] resp);
        logic hs, got_r;
        araddr  = a;
        arvalid = 1'b1;
        hs      = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = arready;
            tick();
        end
        arvalid = 1'b0;
        got_r = 1'b0;
        d     = 8'hEE;
        resp  = 2'b11;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (rvalid) begin
                got_r  = 1'b1;
                d      = rdata;
                resp   = rresp;
                rready = 1'b1;
            end
            tick();
        end
        rready = 1'b0;
        if (!got_r) check_eq("read_timeout", 32'(got_r), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic [1:0] rs;
        logic [1:0] br;
        int         bcnt;

        rst_n = 1'b0;
        awaddr = 8'h00; awvalid = 1'b0; wdata = 8'h00; wvalid = 1'b0; bready = 1'b0;
        araddr = 8'h00; arvalid = 1'b0; rready = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) tick();
        check_eq("rst_awready", 32'(awready), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_bvalid",  32'(bvalid),  32'd0);
        check_eq("rst_rvalid",  32'(rvalid),  32'd0);
        check_eq("rst_flush",   32'(flush),   32'd0);
        check_eq("rst_irq",     32'(irq),     32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_awready", 32'(awready), 32'd1);
        check_eq("post_rst_arready", 32'(arready), 32'd1);

        axi_read(8'h00, rd, rs); check_eq("rst_ctrl", 32'(rd), 32'h00); check_eq("rst_ctrl_resp", 32'(rs), 32'd0);
        axi_read(8'h01, rd, rs); check_eq("rst_status", 32'(rd), 32'h00); check_eq("rst_status_resp", 32'(rs), 32'd0);
        axi_read(8'h02, rd, rs); check_eq("rst_event", 32'(rd), 32'h00); check_eq("rst_event_resp", 32'(rs), 32'd0);
        axi_read(8'h03, rd, rs); check_eq("rst_fcnt", 32'(rd), 32'h00); check_eq("rst_fcnt_resp", 32'(rs), 32'd0);

        // ---------------- flush timing (hold = 8) ----------------
        axi_write(8'h00, 8'h01, br);
        check_eq("flush_at_set_edge", 32'(flush_at_upd), 32'd0);
        check_eq("flush_set+1", 32'(flush), 32'd1);
        check_eq("ctrl_wr_resp", 32'(br), 32'd0);
        repeat (10) tick();
        axi_read(8'h03, rd, rs); check_eq("fcnt_1", 32'(rd), 32'h01);
        axi_write(8'h00, 8'h00, br);          // returns at clear edge + 1
        check_eq("flush_clr+1", 32'(flush), 32'd1);
        repeat (6) tick();
        check_eq("flush_clr+7", 32'(flush), 32'd1);
        tick();
        check_eq("flush_clr+8", 32'(flush), 32'd0);

        axi_write(8'h00, 8'h01, br);
        axi_write(8'h00, 8'h00, br);
        axi_read(8'h01, rd, rs); check_eq("status_busy_hold", 32'(rd), 32'h04);
        repeat (10) tick();
        axi_read(8'h01, rd, rs); check_eq("status_idle", 32'(rd), 32'h00);
        axi_read(8'h03, rd, rs); check_eq("fcnt_2", 32'(rd), 32'h02);

        // ---------------- staggered beats, slow bready ----------------
        awaddr = 8'h00; awvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0;
        check_eq("aw_held_ready", 32'(awready), 32'd0);
        check_eq("aw_only_bvalid", 32'(bvalid), 32'd0);
        tick(); tick();
        wdata = 8'h02; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid) bcnt++;
            if (i == 3) bready = 1'b1;
            else tick();
        end
        check_eq("stag_bresp", 32'(bresp), 32'd0);
        tick();
        bready = 1'b0;
        check_eq("stag_bvalid_cycles", 32'(bcnt), 32'd4);
        check_eq("stag_bvalid_drop", 32'(bvalid), 32'd0);
        axi_read(8'h00, rd, rs); check_eq("stag_ctrl", 32'(rd), 32'h02);
        axi_read(8'h03, rd, rs); check_eq("stag_fcnt", 32'(rd), 32'h02);

        // ---------------- full flag, EVENT and irq ----------------
        fifo_full = 1'b1;
        tick(); tick(); tick();
        check_eq("irq_full+3", 32'(irq), 32'd0);
        tick();
        check_eq("irq_full+4", 32'(irq), 32'd1);
        axi_read(8'h01, rd, rs); check_eq("status_full", 32'(rd), 32'h02);
        axi_read(8'h02, rd, rs); check_eq("event_full", 32'(rd), 32'h01);
        axi_write(8'h02, 8'h01, br);
        check_eq("irq_after_w1c", 32'(irq), 32'd0);
        axi_read(8'h02, rd, rs); check_eq("event_cleared", 32'(rd), 32'h00);

        fifo_full = 1'b0;
        repeat (5) tick();
        fifo_full = 1'b1;                      // rise seen on the 3rd edge from here
        tick(); tick();
        axi_write(8'h02, 8'h01, br);           // update on that same 3rd edge
        axi_read(8'h02, rd, rs); check_eq("event_set_wins", 32'(rd), 32'h01);
        check_eq("irq_set_wins", 32'(irq), 32'd1);

        fifo_empty = 1'b1;
        repeat (5) tick();
        axi_read(8'h02, rd, rs); check_eq("event_both", 32'(rd), 32'h03);
        axi_read(8'h01, rd, rs); check_eq("status_both", 32'(rd), 32'h03);

        // ---------------- out-of-range addresses ----------------
        axi_read(8'h07, rd, rs);
        check_eq("bad_rd_data", 32'(rd), 32'h00);
        check_eq("bad_rd_resp", 32'(rs), 32'd2);
        axi_write(8'h05, 8'hFF, br);
        check_eq("bad_wr_resp", 32'(br), 32'd2);
        axi_write(8'h01, 8'hFF, br);
        check_eq("ro_wr_resp", 32'(br), 32'd0);
        axi_read(8'h00, rd, rs); check_eq("bad_wr_ctrl", 32'(rd), 32'h02);
        axi_read(8'h02, rd, rs); check_eq("bad_wr_event", 32'(rd), 32'h03);
        axi_read(8'h03, rd, rs); check_eq("bad_wr_fcnt", 32'(rd), 32'h02);

        // ---------------- FLUSH_CNT saturation, reset in hold ----------------
        for (int i = 0; i < 300; i++) begin
            axi_write(8'h00, 8'h01, br);
            axi_write(8'h00, 8'h00, br);
        end
        axi_read(8'h03, rd, rs); check_eq("fcnt_sat", 32'(rd), 32'hFF);
        repeat (12) tick();
        axi_write(8'h00, 8'h01, br);
        axi_write(8'h00, 8'h00, br);
        tick(); tick();
        check_eq("flush_in_hold", 32'(flush), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("flush_rst_hold", 32'(flush), 32'd0);
        rst_n = 1'b1;
        tick();
        axi_read(8'h03, rd, rs); check_eq("fcnt_after_rst", 32'(rd), 32'h00);
        axi_read(8'h00, rd, rs); check_eq("ctrl_after_rst", 32'(rd), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_fifo_csr_ctrl
`default_nettype wire
